// File: rtl/uart_frame_pkg.sv
// Shared constants and state encoding for the UART frame receive path.
package uart_frame_pkg;

  localparam logic [7:0] SOF = 8'hA5;

  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_CHK     = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    PAYLOAD,
    CHK,
    DRAIN
  } state_t;

endpackage

// File: rtl/uart_frame_buf.sv
// Payload store: one synchronous write port, one combinational read port.
module uart_frame_buf #(
  parameter int MAX_LEN = 16,
  parameter int PTR_W   = 4
) (
  input  logic             i_Clock,
  input  logic             wr_en,
  input  logic [PTR_W-1:0] wr_addr,
  input  logic [7:0]       wr_data,
  input  logic [PTR_W-1:0] rd_addr,
  output logic [7:0]       rd_data
);

  logic [7:0] mem [MAX_LEN];

  always_ff @(posedge i_Clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_rx_deframer.sv
// Hunts SOF/LEN/PAYLOAD/CHK frames in the UART byte stream, validates them and
// streams the buffered payload out over a valid/ready byte interface.
module uart_rx_deframer
  import uart_frame_pkg::*;
#(
  parameter int MAX_LEN      = 16,
  parameter int TIMEOUT_CLKS = 10000
) (
  input  logic       i_Clock,
  input  logic       i_Rst_L,
  input  logic       i_RX_DV,
  input  logic [7:0] i_RX_Byte,
  output logic [7:0] o_Data,
  output logic       o_Valid,
  input  logic       i_Ready,
  output logic       o_Last,
  output logic [7:0] o_Frame_Len,
  output logic       o_Err,
  output logic [1:0] o_Err_Code,
  output logic       o_Overrun
);

  localparam int PTR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TO_W  = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CLKS - 1);
  localparam logic [7:0]      MAX_LEN_B = 8'(MAX_LEN);

  state_t            state;
  logic [7:0]        len;
  logic [7:0]        acc;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [TO_W-1:0]   to_cnt;
  logic [7:0]        rd_data;
  logic [7:0]        len_m1;
  logic [7:0]        chk_sum;
  logic              in_frame;
  logic              to_hit;
  logic              buf_we;

  function automatic logic len_ok(input logic [7:0] b);
    return (b != 8'd0) && (b <= MAX_LEN_B);
  endfunction

  assign len_m1   = len - 8'd1;
  assign chk_sum  = acc + i_RX_Byte;
  assign in_frame = (state == LEN) || (state == PAYLOAD) || (state == CHK);
  // A byte arriving on the expiry cycle takes priority over the timeout.
  assign to_hit   = in_frame && !i_RX_DV && (to_cnt == TO_LAST);
  assign buf_we   = (state == PAYLOAD) && i_RX_DV;
  assign o_Data   = o_Valid ? rd_data : 8'h00;

  uart_frame_buf #(
    .MAX_LEN (MAX_LEN),
    .PTR_W   (PTR_W)
  ) u_buf (
    .i_Clock (i_Clock),
    .wr_en   (buf_we),
    .wr_addr (wr_ptr),
    .wr_data (i_RX_Byte),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state       <= IDLE;
      len         <= 8'd0;
      acc         <= 8'd0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      to_cnt      <= '0;
      o_Valid     <= 1'b0;
      o_Last      <= 1'b0;
      o_Frame_Len <= 8'd0;
      o_Err       <= 1'b0;
      o_Err_Code  <= 2'd0;
      o_Overrun   <= 1'b0;
    end else begin
      o_Err     <= 1'b0;
      o_Overrun <= 1'b0;

      if (in_frame && !i_RX_DV && !to_hit) to_cnt <= to_cnt + TO_W'(1);
      else                                 to_cnt <= '0;

      if (to_hit) begin
        o_Err      <= 1'b1;
        o_Err_Code <= ERR_TIMEOUT;
        state      <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (i_RX_DV && (i_RX_Byte == SOF)) state <= LEN;
          end
          LEN: begin
            if (i_RX_DV) begin
              if (!len_ok(i_RX_Byte)) begin
                o_Err      <= 1'b1;
                o_Err_Code <= ERR_LEN;
                state      <= IDLE;
              end else begin
                len    <= i_RX_Byte;
                acc    <= i_RX_Byte;
                wr_ptr <= '0;
                state  <= PAYLOAD;
              end
            end
          end
          PAYLOAD: begin
            if (i_RX_DV) begin
              acc <= chk_sum;
              if (8'(wr_ptr) == len_m1) state  <= CHK;
              else                      wr_ptr <= wr_ptr + PTR_W'(1);
            end
          end
          CHK: begin
            if (i_RX_DV) begin
              if (chk_sum == 8'd0) begin
                state       <= DRAIN;
                rd_ptr      <= '0;
                o_Valid     <= 1'b1;
                o_Last      <= (len == 8'd1);
                o_Frame_Len <= len;
              end else begin
                o_Err      <= 1'b1;
                o_Err_Code <= ERR_CHK;
                state      <= IDLE;
              end
            end
          end
          DRAIN: begin
            // Input is not parsed while draining; anything arriving is lost.
            o_Overrun <= i_RX_DV;
            if (i_Ready) begin
              if (o_Last) begin
                state       <= IDLE;
                o_Valid     <= 1'b0;
                o_Last      <= 1'b0;
                o_Frame_Len <= 8'd0;
              end else begin
                rd_ptr <= rd_ptr + PTR_W'(1);
                o_Last <= ((8'(rd_ptr) + 8'd1) == len_m1);
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Scoreboard bench for uart_rx_deframer: directed frames plus randomized traffic.
module tb_uart_rx_deframer;

  localparam int MAX_LEN = 16;
  localparam int TO      = 40;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       dv = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic [7:0] data;
  logic       valid;
  logic       ready = 1'b0;
  logic       last;
  logic [7:0] flen;
  logic       err;
  logic [1:0] ecode;
  logic       ovr;

  always #5 clk = ~clk;

  uart_rx_deframer #(.MAX_LEN(MAX_LEN), .TIMEOUT_CLKS(TO)) dut (
    .i_Clock     (clk),
    .i_Rst_L     (rst_n),
    .i_RX_DV     (dv),
    .i_RX_Byte   (rx_byte),
    .o_Data      (data),
    .o_Valid     (valid),
    .i_Ready     (ready),
    .o_Last      (last),
    .o_Frame_Len (flen),
    .o_Err       (err),
    .o_Err_Code  (ecode),
    .o_Overrun   (ovr)
  );

  typedef struct {
    logic [7:0] d;
    logic       l;
    logic [7:0] n;
  } beat_t;

  beat_t      exp_q[$];
  logic [1:0] err_q[$];
  int         exp_ovr = 0;
  int         n_cmp = 0;
  int         n_bad = 0;
  bit         rand_rdy = 1'b0;

  task automatic check(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    dv = 1'b1;
    rx_byte = b;
    tick();
    dv = 1'b0;
    repeat (gap) tick();
  endtask

  function automatic logic [7:0] good_chk(input logic [7:0] len, input logic [7:0] pl[$]);
    int s = len;
    foreach (pl[i]) s += pl[i];
    return 8'(0 - s);
  endfunction

  // Reference: decide the frame's fate from the framing rules, queue the
  // expected outcome, then put the bytes on the wire.
  task automatic do_frame(input logic [7:0] len, input logic [7:0] pl[$],
                          input logic [7:0] chk, input int gmax);
    int s = len + chk;
    foreach (pl[i]) s += pl[i];
    if (len == 0 || len > MAX_LEN) begin
      err_q.push_back(2'd1);
      send(8'hA5, $urandom_range(0, gmax));
      send(len, $urandom_range(0, gmax));
    end else begin
      if (s % 256 == 0) begin
        for (int i = 0; i < len; i++) exp_q.push_back('{pl[i], (i == len - 1), len});
      end else begin
        err_q.push_back(2'd2);
      end
      send(8'hA5, $urandom_range(0, gmax));
      send(len, $urandom_range(0, gmax));
      foreach (pl[i]) send(pl[i], $urandom_range(0, gmax));
      send(chk, (gmax == 0) ? 0 : $urandom_range(0, gmax));
    end
  endtask

  task automatic wait_drain();
    int b = 0;
    while (exp_q.size() != 0 && b < 400) begin
      tick();
      b++;
    end
    check("drain_complete_pending", exp_q.size(), 0);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents something.
  logic       prev_stall = 1'b0;
  logic [7:0] prev_d = 8'h00;
  logic       prev_l = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      beat_t e;
      if (prev_stall) begin
        check("hold_valid", valid, 1);
        check("hold_data", data, prev_d);
        check("hold_last", last, prev_l);
      end
      if (!valid) check("idle_last_flen", {last, flen}, 0);
      if (valid && ready) begin
        check("beat_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("data", data, e.d);
          check("last", last, e.l);
          check("frame_len", flen, e.n);
        end
      end
      if (err) begin
        check("err_expected", err_q.size() > 0, 1);
        if (err_q.size() > 0) check("err_code", ecode, err_q.pop_front());
      end
      if (ovr) begin
        check("overrun_expected", exp_ovr > 0, 1);
        if (exp_ovr > 0) exp_ovr--;
      end
      check("err_ovr_exclusive", err && ovr, 0);
      prev_stall = valid && !ready;
      prev_d = data;
      prev_l = last;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pl[$];
    logic [7:0] len;
    logic [7:0] chk;
    int kind;

    repeat (3) tick();
    check("reset_outputs", {data, valid, last, flen, err, ecode, ovr}, 0);
    rst_n = 1'b1;
    tick();
    ready = 1'b1;

    // Good frame, latency and back-to-back streaming.
    pl = '{8'h11, 8'h22, 8'h33};
    do_frame(8'd3, pl, 8'h97, 0);
    check("latency_valid", valid, 1);
    check("first_data", data, 8'h11);
    repeat (3) tick();
    check("stream_3_cycles", valid, 0);

    // Bad checksum then a good frame.
    do_frame(8'd3, pl, 8'h98, 0);
    repeat (2) tick();
    check("badchk_no_valid", valid, 0);
    do_frame(8'd3, pl, 8'h97, 0);
    wait_drain();

    // Length faults.
    pl = {};
    do_frame(8'h00, pl, 8'h00, 0);
    do_frame(8'h11, pl, 8'h00, 0);
    repeat (3) tick();

    // Timeout, then a byte landing exactly on the expiry cycle.
    err_q.push_back(2'd3);
    send(8'hA5, 0);
    send(8'h02, 0);
    send(8'h11, TO);
    repeat (3) tick();
    exp_q.push_back('{8'h11, 1'b0, 8'd2});
    exp_q.push_back('{8'h22, 1'b1, 8'd2});
    send(8'hA5, 0);
    send(8'h02, 0);
    send(8'h11, TO - 1);
    send(8'h22, 0);
    send(8'hCB, 0);
    wait_drain();

    // Backpressure and overrun.
    ready = 1'b0;
    pl = '{8'h7E};
    do_frame(8'd1, pl, 8'h81, 1);
    repeat (3) tick();
    check("bp_valid", valid, 1);
    check("bp_data", data, 8'h7E);
    check("bp_last", last, 1);
    check("bp_flen", flen, 1);
    exp_ovr++;
    send(8'h55, 1);
    check("ovr_data_held", data, 8'h7E);
    check("ovr_valid_held", valid, 1);
    ready = 1'b1;
    tick();
    check("bp_done_idle", valid, 0);

    // Noise before a frame.
    send(8'h00, 1);
    send(8'hFF, 1);
    do_frame(8'd1, pl, 8'h81, 1);
    wait_drain();

    // Reset mid-frame and mid-drain.
    send(8'hA5, 0);
    send(8'h02, 0);
    rst_n = 1'b0;
    tick();
    check("rst_midframe_outputs", {data, valid, last, flen, err, ecode, ovr}, 0);
    rst_n = 1'b1;
    tick();
    ready = 1'b0;
    send(8'hA5, 0); send(8'h01, 0); send(8'h7E, 0); send(8'h81, 0);
    check("pre_rst_drain_valid", valid, 1);
    rst_n = 1'b0;
    tick();
    check("rst_middrain_outputs", {data, valid, last, flen, err, ecode, ovr}, 0);
    rst_n = 1'b1;
    ready = 1'b1;
    tick();
    pl = '{8'h11, 8'h22, 8'h33};
    do_frame(8'd3, pl, 8'h97, 0);
    wait_drain();

    // Randomized traffic.
    rand_rdy = 1'b1;
    for (int f = 0; f < 80; f++) begin
      repeat ($urandom_range(0, 2)) begin
        logic [7:0] nb;
        nb = 8'($urandom_range(0, 255));
        if (nb == 8'hA5) nb = 8'h5A;
        send(nb, $urandom_range(0, 3));
      end
      kind = $urandom_range(0, 9);
      if (kind == 0)      len = 8'd0;
      else if (kind == 1) len = 8'($urandom_range(MAX_LEN + 1, 255));
      else                len = 8'($urandom_range(1, MAX_LEN));
      pl = {};
      if (len != 0 && len <= MAX_LEN)
        for (int i = 0; i < len; i++) pl.push_back(8'($urandom_range(0, 255)));
      chk = good_chk(len, pl);
      if ($urandom_range(0, 3) == 0) chk = chk + 8'($urandom_range(1, 255));
      do_frame(len, pl, chk, 3);
      wait_drain();
    end
    rand_rdy = 1'b0;
    ready = 1'b1;
    repeat (20) tick();

    check("beats_left", exp_q.size(), 0);
    check("errs_left", err_q.size(), 0);
    check("overruns_left", exp_ovr, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
